// File: rtl/logic_unit_ctrl_pkg.sv
// Shared definitions for the logic-unit controller: opcodes, FSM encoding,
// the queued command layout and a reference evaluation of the logic unit.
package logic_unit_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 2 + 2 * DATA_W;  // {op, a, b} = 66 bits

  localparam logic [1:0] OP_ILLEGAL = 2'b00;
  localparam logic [1:0] OP_AND     = 2'b01;
  localparam logic [1:0] OP_OR      = 2'b10;
  localparam logic [1:0] OP_XOR     = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  // What a healthy logic unit produces for a given select and operands.
  function automatic logic [DATA_W-1:0] logic_eval(input logic [1:0]        op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_ctrl_if.sv
// Command and response channels of the logic-unit controller.
// master: the requester (drives commands, accepts responses).
// slave:  the controller.
interface logic_unit_ctrl_if;
  import logic_unit_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/logic_unit_ctrl_fifo.sv
// logic_cmd_fifo: synchronous FIFO holding queued commands. The head entry
// is read combinationally; a push becomes visible at the head one cycle
// later (no write-to-read bypass). Pointers wrap modulo DEPTH (power of 2).
module logic_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 66,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; simultaneous push and pop leave count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/logic_unit_ctrl.sv
// logic_unit_ctrl: queued front-end for the 32-bit AND/OR/XOR logic unit.
// Commands are queued, presented to the unit on registered l_* outputs,
// held for SETTLE_CYCLES, and the captured result is returned on the
// response channel. Select 2'b00 is never presented; such requests are
// answered with rsp_err=1, rsp_data=0.
// Optional: define LOGIC_UNIT_CTRL_SELFCHECK_EN to compare l_out against
// an internal recomputation at capture time (flags rsp_err and sticky
// chk_fail on mismatch). Without it chk_fail is tied low.
module logic_unit_ctrl
  import logic_unit_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_ctrl_if.slave  bus,
  output logic [1:0]        l_f1f0,
  output logic [DATA_W-1:0] l_a,
  output logic [DATA_W-1:0] l_b,
  input  logic [DATA_W-1:0] l_out,
  output logic              busy,
  output logic              chk_fail
);

  localparam int         CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        l_f1f0_q, l_f1f0_d;
  logic [DATA_W-1:0] l_a_q, l_a_d;
  logic [DATA_W-1:0] l_b_q, l_b_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CMD_W-1:0]  fifo_dout;
  cmd_t              head;
  logic              capture;
  logic              chk_mis;

  assign fifo_push = bus.cmd_valid && !fifo_full;
  assign head      = cmd_t'(fifo_dout);
  assign capture   = (state_q == ST_WAIT) && (cnt_q == '0);

  logic_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({bus.cmd_op, bus.cmd_a, bus.cmd_b}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state and register-input logic for the IDLE/WAIT/RESP sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    l_f1f0_d    = l_f1f0_q;
    l_a_d       = l_a_q;
    l_b_d       = l_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head.op != OP_ILLEGAL) begin
            l_f1f0_d = head.op;
            l_a_d    = head.a;
            l_b_d    = head.b;
            cnt_d    = SETTLE_LOAD;
            state_d  = ST_WAIT;
          end else begin
            // l_* keep the last legal command so the unit never sees 00.
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (capture) begin
          rsp_data_d  = l_out;
          rsp_err_d   = chk_mis;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, operand and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      l_f1f0_q    <= OP_AND;
      l_a_q       <= '0;
      l_b_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      l_f1f0_q    <= l_f1f0_d;
      l_a_q       <= l_a_d;
      l_b_q       <= l_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef LOGIC_UNIT_CTRL_SELFCHECK_EN
  logic chk_fail_q, chk_fail_d;

  assign chk_mis = (l_out != logic_eval(l_f1f0_q, l_a_q, l_b_q));

  // chk_fail latches on the first mismatching capture and holds until reset.
  always_comb begin
    chk_fail_d = chk_fail_q;
    if (capture && chk_mis) chk_fail_d = 1'b1;
  end

  // Sticky failure flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_fail_q <= 1'b0;
    else        chk_fail_q <= chk_fail_d;
  end

  assign chk_fail = chk_fail_q;
`else
  assign chk_mis  = 1'b0;
  assign chk_fail = 1'b0;
`endif

  assign l_f1f0        = l_f1f0_q;
  assign l_a           = l_a_q;
  assign l_b           = l_b_q;
  assign bus.cmd_ready = !fifo_full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
